usb_rx_ctrl: RTL and testbench
==============================

# usb_rx_ctrl

Transaction controller for the USB 1.1 receive path. Sits downstream of `USB_RX` and consumes its packet-level outputs. Sequences each OUT/SETUP token → DATA0/DATA1 → handshake transaction. It forwards payload bytes to the endpoint buffer, tracks the data toggle, and decides ACK, NAK or silence. It then holds a handshake request toward the transmitter until that request is serviced.

## Interface
Parameters:
- `MAX_BYTES`, 64: maximum payload bytes accepted per DATA packet.
- `TIMEOUT_CYCLES`, 1024: cycles allowed between token and DATA end. Used only with the timeout feature.

Ports. One clock; reset is synchronous and active-low.
- `clk` input 1: system clock.
- `n_rst` input 1: synchronous active-low reset.
- `RX_Packet` input 4: packet ID code from `USB_RX`. Valid only while `RX_Data_Ready` is high.
- `RX_Data_Ready` input 1: one-cycle pulse at packet completion (after EOP).
- `RX_Error` input 1: one-cycle pulse on a receive error.
- `Store_RX_Packet_Data` input 1: one-cycle pulse per received payload byte.
- `RX_Packet_Data` input 8: payload byte, valid with `Store_RX_Packet_Data`.
- `buf_ready` input 1: endpoint buffer can accept a packet.
- `tx_done` input 1: transmitter finished sending the requested handshake.
- `buf_w_en` output 1: buffer write strobe.
- `buf_w_data` output 8: buffer write data.
- `commit` output 1: pulse; buffered packet is valid.
- `flush` output 1: pulse; buffer must discard bytes written this transaction.
- `byte_count` output 7: bytes written in the current or last transaction.
- `tx_req` output 1: handshake request.
- `tx_packet` output 2: handshake code.
- `toggle` output 1: expected data toggle (0 = DATA0).

## Operation
Packet ID codes, defined in the package: `NONE`=0, `OUT`=1, `IN`=2, `DATA0`=3, `DATA1`=4, `ACK`=5, `NAK`=6, `SETUP`=7.

Handshake codes: `HS_NONE`=0, `HS_ACK`=1, `HS_NAK`=2.

States:
- **IDLE**
  - `RX_Data_Ready` with `OUT` → WAIT_DATA.
  - `RX_Data_Ready` with `SETUP` → WAIT_DATA, and `toggle` is forced to 0.
  - All other packets are ignored.
  - Clear `byte_count` and the `nak` and `ovf` flags on entry to WAIT_DATA.
- **WAIT_DATA**
  - When `buf_ready`=0 on the first `Store_RX_Packet_Data`, set `nak`.
  - On each store while `nak`=0 and `byte_count` < `MAX_BYTES`: assert `buf_w_en` and `buf_w_data`, then increment `byte_count`.
  - A store at `byte_count` = `MAX_BYTES` sets `ovf`; no write occurs.
  - `RX_Error` → pulse `flush`, go to IDLE, send no handshake.
  - `RX_Data_Ready` with a non-DATA code → pulse `flush`, go to IDLE.
  - `RX_Data_Ready` with DATA0/DATA1, evaluated in priority order:
    - `nak` or `ovf` set → `flush`, `HS_NAK`.
    - PID toggle ≠ `toggle` → `flush`, `HS_ACK`; the packet is a retransmitted duplicate.
    - Otherwise → `commit`, `HS_ACK`, and `toggle` inverts.
    - All three cases go to RESPOND.
- **RESPOND**
  - Hold `tx_req`=1 and `tx_packet` stable until `tx_done`.
  - On `tx_done`, deassert `tx_req` and go to IDLE.
  - RX inputs are ignored in this state.

Boundary conditions:
- `RX_Error` and `RX_Data_Ready` in the same cycle: the error wins.
- `Store_RX_Packet_Data` in the same cycle as `RX_Data_Ready`: the byte is written and counted first, and the decision uses the updated count.
- Exactly `MAX_BYTES` bytes → accepted. `MAX_BYTES`+1 → NAK.
- A zero-length DATA packet is legal: `commit` with `byte_count`=0.
- `toggle` persists across transactions. Only reset or a SETUP token changes it, apart from successful commits.

## Timing
- Reset values: all outputs 0. State is IDLE and `toggle`=0. Reset mid-transaction aborts it with no `flush` and no handshake.
- `buf_w_en` and `buf_w_data` are registered and appear 1 cycle after `Store_RX_Packet_Data`.
- `commit`/`flush` pulse exactly 1 cycle, in the cycle after the deciding `RX_Data_Ready` or `RX_Error`.
- `tx_req` rises in the same cycle as `commit`/`flush`.
- Earliest return to IDLE is 1 cycle after `tx_done` is sampled. The minimum transaction is token, DATA, plus 2 cycles.

## Configuration
- `USB_RX_CTRL_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT_DATA.
  - When it reaches `TIMEOUT_CYCLES` with no DATA decision, pulse `flush`, send no handshake, and go to IDLE.
  - The counter clears on state entry.
- Undefined: no counter; WAIT_DATA waits indefinitely.

## Structure
- Package `usb_rx_pkg` holds:
  - the PID code constants;
  - the handshake code constants;
  - the state enum `rx_ctrl_state_t` (IDLE, WAIT_DATA, RESPOND).
- Sub-module: the existing `flex_counter`, instantiated for the timeout counter under the macro. The byte count stays inline because its saturate-and-flag behaviour differs from `flex_counter`.

## Test plan
- OUT, then DATA0 with 8 bytes 0x01..0x08, `buf_ready`=1 → 8 `buf_w_en` pulses with matching data; `commit`; `HS_ACK`; `toggle`=1.
- Repeat that DATA0 after `toggle`=1 → `flush`, `HS_ACK`, `toggle` stays 1, no `commit`.
- OUT, then DATA1 with 65 bytes, `MAX_BYTES`=64 → 64 writes, `flush`, `HS_NAK`, `toggle` unchanged.
- OUT, then DATA0 with `buf_ready`=0 → zero writes, `HS_NAK`. Separately, `RX_Error` mid-DATA → `flush`, `tx_req` stays 0, state IDLE.
- `toggle`=1, then SETUP, then DATA0 with 8 bytes → `commit`, `HS_ACK`, `toggle`=1. Hold `tx_done`=0 for 5 cycles → `tx_req` held for those 5 cycles.
- With `USB_RX_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: OUT, then silence → `flush` at cycle 16 after the token, no handshake, state IDLE.

Source files
------------

// File: rtl/usb_rx_ctrl_pkg.sv
// Shared PID/handshake codes, FSM state type and PID helpers for the USB 1.1
// receive transaction controller.
package usb_rx_pkg;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] OUT   = 4'd1;
  localparam logic [3:0] IN    = 4'd2;
  localparam logic [3:0] DATA0 = 4'd3;
  localparam logic [3:0] DATA1 = 4'd4;
  localparam logic [3:0] ACK   = 4'd5;
  localparam logic [3:0] NAK   = 4'd6;
  localparam logic [3:0] SETUP = 4'd7;

  localparam logic [1:0] HS_NONE = 2'd0;
  localparam logic [1:0] HS_ACK  = 2'd1;
  localparam logic [1:0] HS_NAK  = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    RESPOND   = 2'd2
  } rx_ctrl_state_t;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == DATA0) || (pid == DATA1);
  endfunction

  function automatic logic pid_toggle(input logic [3:0] pid);
    return (pid == DATA1);
  endfunction

endpackage

// File: rtl/usb_rx_ctrl_flex_counter.sv
// Generic up-counter with clear, enable and programmable rollover value.
// Synchronous active-low reset.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) count_out <= '0;
      else                           count_out <= count_out + 1'b1;
    end
  end

  assign rollover_flag = count_enable && (count_out == rollover_val);

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB 1.1 OUT/SETUP receive transaction controller: payload forwarding, data
// toggle tracking and ACK/NAK decision. Optional WAIT_DATA timeout: USB_RX_CTRL_TIMEOUT_EN.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter int MAX_BYTES      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] RX_Packet,
  input  logic       RX_Data_Ready,
  input  logic       RX_Error,
  input  logic       Store_RX_Packet_Data,
  input  logic [7:0] RX_Packet_Data,
  input  logic       buf_ready,
  input  logic       tx_done,
  output logic       buf_w_en,
  output logic [7:0] buf_w_data,
  output logic       commit,
  output logic       flush,
  output logic [6:0] byte_count,
  output logic       tx_req,
  output logic [1:0] tx_packet,
  output logic       toggle
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  rx_ctrl_state_t state, state_nxt;

  logic       nak, nak_nxt;
  logic       ovf, ovf_nxt;
  logic       seen, seen_nxt;
  logic       w_en_nxt;
  logic [7:0] w_data_nxt;
  logic       commit_nxt;
  logic       flush_nxt;
  logic [6:0] count_nxt;
  logic       tx_req_nxt;
  logic [1:0] tx_packet_nxt;
  logic       toggle_nxt;
  logic       timeout;

`ifdef USB_RX_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] unused_to_count;

  // Counter is held clear outside WAIT_DATA, so it restarts at 0 on each entry.
  flex_counter #(
    .NUM_CNT_BITS(TO_W)
  ) u_timeout (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state != WAIT_DATA),
    .count_enable (state == WAIT_DATA),
    .rollover_val (TO_W'(TIMEOUT_CYCLES - 1)),
    .count_out    (unused_to_count),
    .rollover_flag(timeout)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      nak        <= 1'b0;
      ovf        <= 1'b0;
      seen       <= 1'b0;
      buf_w_en   <= 1'b0;
      buf_w_data <= 8'd0;
      commit     <= 1'b0;
      flush      <= 1'b0;
      byte_count <= 7'd0;
      tx_req     <= 1'b0;
      tx_packet  <= HS_NONE;
      toggle     <= 1'b0;
    end else begin
      state      <= state_nxt;
      nak        <= nak_nxt;
      ovf        <= ovf_nxt;
      seen       <= seen_nxt;
      buf_w_en   <= w_en_nxt;
      buf_w_data <= w_data_nxt;
      commit     <= commit_nxt;
      flush      <= flush_nxt;
      byte_count <= count_nxt;
      tx_req     <= tx_req_nxt;
      tx_packet  <= tx_packet_nxt;
      toggle     <= toggle_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    nak_nxt       = nak;
    ovf_nxt       = ovf;
    seen_nxt      = seen;
    w_en_nxt      = 1'b0;
    w_data_nxt    = buf_w_data;
    commit_nxt    = 1'b0;
    flush_nxt     = 1'b0;
    count_nxt     = byte_count;
    tx_req_nxt    = tx_req;
    tx_packet_nxt = tx_packet;
    toggle_nxt    = toggle;

    unique case (state)
      IDLE: begin
        if (RX_Data_Ready && (RX_Packet == OUT || RX_Packet == SETUP)) begin
          state_nxt = WAIT_DATA;
          count_nxt = 7'd0;
          nak_nxt   = 1'b0;
          ovf_nxt   = 1'b0;
          seen_nxt  = 1'b0;
          if (RX_Packet == SETUP) toggle_nxt = 1'b0;
        end
      end

      WAIT_DATA: begin
        // Byte handling comes first so a same-cycle decision sees its effect.
        if (Store_RX_Packet_Data) begin
          seen_nxt = 1'b1;
          if (!seen && !buf_ready) nak_nxt = 1'b1;
          if (!nak_nxt) begin
            if (byte_count < MAX_CNT) begin
              w_en_nxt   = 1'b1;
              w_data_nxt = RX_Packet_Data;
              count_nxt  = byte_count + 7'd1;
            end else begin
              ovf_nxt = 1'b1;
            end
          end
        end

        if (RX_Error) begin
          flush_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (RX_Data_Ready) begin
          if (is_data_pid(RX_Packet)) begin
            state_nxt  = RESPOND;
            tx_req_nxt = 1'b1;
            if (nak_nxt || ovf_nxt) begin
              flush_nxt     = 1'b1;
              tx_packet_nxt = HS_NAK;
            end else if (pid_toggle(RX_Packet) != toggle) begin
              // Host missed our last ACK and resent; ack it but drop the data.
              flush_nxt     = 1'b1;
              tx_packet_nxt = HS_ACK;
            end else begin
              commit_nxt    = 1'b1;
              tx_packet_nxt = HS_ACK;
              toggle_nxt    = ~toggle;
            end
          end else begin
            flush_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end else if (timeout) begin
          flush_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end

      RESPOND: begin
        if (tx_done) begin
          tx_req_nxt    = 1'b0;
          tx_packet_nxt = HS_NONE;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed scoreboard bench for usb_rx_ctrl: buffer writes and commit/flush
// handshakes are queued at stimulus time and checked when the DUT emits them.
module tb_usb_rx_ctrl;
  import usb_rx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] RX_Packet;
  logic       RX_Data_Ready;
  logic       RX_Error;
  logic       Store_RX_Packet_Data;
  logic [7:0] RX_Packet_Data;
  logic       buf_ready;
  logic       tx_done;
  logic       buf_w_en;
  logic [7:0] buf_w_data;
  logic       commit;
  logic       flush;
  logic [6:0] byte_count;
  logic       tx_req;
  logic [1:0] tx_packet;
  logic       toggle;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] wq[$];
  logic [4:0] hq[$];

  usb_rx_ctrl #(
    .MAX_BYTES     (64),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .RX_Packet           (RX_Packet),
    .RX_Data_Ready       (RX_Data_Ready),
    .RX_Error            (RX_Error),
    .Store_RX_Packet_Data(Store_RX_Packet_Data),
    .RX_Packet_Data      (RX_Packet_Data),
    .buf_ready           (buf_ready),
    .tx_done             (tx_done),
    .buf_w_en            (buf_w_en),
    .buf_w_data          (buf_w_data),
    .commit              (commit),
    .flush               (flush),
    .byte_count          (byte_count),
    .tx_req              (tx_req),
    .tx_packet           (tx_packet),
    .toggle              (toggle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every write and every commit/flush pulse must match the queue head.
  always @(negedge clk) begin
    if (buf_w_en === 1'b1) begin
      check("pending_write", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) check("buf_w_data", 32'(buf_w_data), 32'(wq.pop_front()));
    end
    if (commit === 1'b1 || flush === 1'b1) begin
      check("pending_handshake", 32'(hq.size() != 0), 32'd1);
      if (hq.size() != 0) check("commit_flush_hs", 32'({commit, flush, tx_req, tx_packet}), 32'(hq.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pid(input logic [3:0] pid);
    RX_Packet     = pid;
    RX_Data_Ready = 1'b1;
    step();
    RX_Data_Ready = 1'b0;
    RX_Packet     = NONE;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] first, input int nwr);
    for (int i = 0; i < n; i++) begin
      Store_RX_Packet_Data = 1'b1;
      RX_Packet_Data       = first + 8'(i);
      if (i < nwr) wq.push_back(RX_Packet_Data);
      step();
    end
    Store_RX_Packet_Data = 1'b0;
  endtask

  task automatic expect_hs(input logic c, input logic f, input logic r, input logic [1:0] p);
    hq.push_back({c, f, r, p});
  endtask

  task automatic finish_tx();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("tx_req_after_done", 32'(tx_req), 32'd0);
    check("state_after_done", 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    n_rst = 1'b0;
    RX_Packet = NONE;
    RX_Data_Ready = 1'b0;
    RX_Error = 1'b0;
    Store_RX_Packet_Data = 1'b0;
    RX_Packet_Data = 8'd0;
    buf_ready = 1'b1;
    tx_done = 1'b0;
    step();
    step();
    check("rst_outputs", 32'({buf_w_en, buf_w_data, commit, flush, byte_count, tx_req, tx_packet, toggle}), 32'd0);
    n_rst = 1'b1;
    step();

    // OUT + DATA0, 8 bytes -> commit/ACK, toggle flips
    send_pid(OUT);
    send_bytes(8, 8'h01, 8);
    expect_hs(1'b1, 1'b0, 1'b1, HS_ACK);
    send_pid(DATA0);
    check("t1_byte_count", 32'(byte_count), 32'd8);
    check("t1_toggle", 32'(toggle), 32'd1);
    check("t1_tx_packet", 32'(tx_packet), 32'(HS_ACK));
    finish_tx();

    // Duplicate DATA0 -> flush, ACK, toggle kept
    send_pid(OUT);
    send_bytes(8, 8'h01, 8);
    expect_hs(1'b0, 1'b1, 1'b1, HS_ACK);
    send_pid(DATA0);
    check("t2_toggle", 32'(toggle), 32'd1);
    finish_tx();

    // 65-byte DATA1 -> 64 writes, flush, NAK
    send_pid(OUT);
    send_bytes(65, 8'h40, 64);
    expect_hs(1'b0, 1'b1, 1'b1, HS_NAK);
    send_pid(DATA1);
    check("t3_byte_count", 32'(byte_count), 32'd64);
    check("t3_toggle", 32'(toggle), 32'd1);
    finish_tx();

    // Buffer not ready -> no writes, NAK
    buf_ready = 1'b0;
    send_pid(OUT);
    send_bytes(4, 8'hA0, 0);
    expect_hs(1'b0, 1'b1, 1'b1, HS_NAK);
    send_pid(DATA0);
    check("t4_byte_count", 32'(byte_count), 32'd0);
    check("t4_tx_packet", 32'(tx_packet), 32'(HS_NAK));
    finish_tx();
    buf_ready = 1'b1;

    // RX_Error mid-DATA -> flush, no handshake
    send_pid(OUT);
    send_bytes(3, 8'hB0, 3);
    expect_hs(1'b0, 1'b1, 1'b0, HS_NONE);
    RX_Error = 1'b1;
    step();
    RX_Error = 1'b0;
    check("t5_tx_req", 32'(tx_req), 32'd0);
    check("t5_state", 32'(dut.state), 32'(IDLE));
    step();
    check("t5_tx_req_later", 32'(tx_req), 32'd0);

    // SETUP forces toggle 0, DATA0 commits; tx_done withheld 5 cycles
    send_pid(SETUP);
    check("t6_setup_toggle", 32'(toggle), 32'd0);
    send_bytes(8, 8'hC0, 8);
    expect_hs(1'b1, 1'b0, 1'b1, HS_ACK);
    send_pid(DATA0);
    check("t6_toggle", 32'(toggle), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t6_tx_req_held", 32'({tx_req, tx_packet}), 32'({1'b1, HS_ACK}));
      step();
    end
    finish_tx();

    // Zero-length DATA1 -> commit with byte_count 0
    send_pid(OUT);
    expect_hs(1'b1, 1'b0, 1'b1, HS_ACK);
    send_pid(DATA1);
    check("t7_byte_count", 32'(byte_count), 32'd0);
    check("t7_toggle", 32'(toggle), 32'd0);
    finish_tx();

    // Exactly MAX_BYTES -> accepted
    send_pid(OUT);
    send_bytes(64, 8'h80, 64);
    expect_hs(1'b1, 1'b0, 1'b1, HS_ACK);
    send_pid(DATA0);
    check("t8_byte_count", 32'(byte_count), 32'd64);
    check("t8_toggle", 32'(toggle), 32'd1);
    finish_tx();

    // RX_Error and RX_Data_Ready together -> error wins
    send_pid(OUT);
    send_bytes(2, 8'hD0, 2);
    expect_hs(1'b0, 1'b1, 1'b0, HS_NONE);
    RX_Error = 1'b1;
    RX_Data_Ready = 1'b1;
    RX_Packet = DATA1;
    step();
    RX_Error = 1'b0;
    RX_Data_Ready = 1'b0;
    RX_Packet = NONE;
    check("t9_tx_req", 32'(tx_req), 32'd0);
    check("t9_toggle", 32'(toggle), 32'd1);
    check("t9_state", 32'(dut.state), 32'(IDLE));

    // Reset mid-transaction -> no flush, no handshake, toggle cleared
    send_pid(OUT);
    send_bytes(2, 8'hE0, 2);
    n_rst = 1'b0;
    step();
    check("t10_rst_outputs", 32'({commit, flush, tx_req, toggle, byte_count}), 32'd0);
    n_rst = 1'b1;
    check("t10_state", 32'(dut.state), 32'(IDLE));
    step();

    // Last byte coincides with DATA ready -> counted before the decision
    send_pid(OUT);
    send_bytes(63, 8'h20, 63);
    Store_RX_Packet_Data = 1'b1;
    RX_Packet_Data = 8'h5F;
    wq.push_back(8'h5F);
    RX_Data_Ready = 1'b1;
    RX_Packet = DATA0;
    expect_hs(1'b1, 1'b0, 1'b1, HS_ACK);
    step();
    Store_RX_Packet_Data = 1'b0;
    RX_Data_Ready = 1'b0;
    RX_Packet = NONE;
    check("t11_byte_count", 32'(byte_count), 32'd64);
    check("t11_toggle", 32'(toggle), 32'd1);
    finish_tx();

`ifdef USB_RX_CTRL_TIMEOUT_EN
    begin
      int k;
      send_pid(OUT);
      expect_hs(1'b0, 1'b1, 1'b0, HS_NONE);
      k = 0;
      while (k < 40 && flush !== 1'b1) begin
        step();
        k++;
      end
      check("t12_timeout_cycle", 32'(k), 32'd16);
      check("t12_tx_req", 32'(tx_req), 32'd0);
      check("t12_state", 32'(dut.state), 32'(IDLE));
    end
`endif

    step();
    step();
    check("writes_outstanding", 32'(wq.size()), 32'd0);
    check("handshakes_outstanding", 32'(hq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
